// File: rtl/chi_stage.sv
// Keccak chi step on one 25-bit slice per cycle, with a one-deep output register
// and slice/round tagging for the downstream addRC stage.
module chi_stage #(
   parameter int SLICES = 64,
   parameter int ROUNDS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] in_slice,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [24:0] out_slice,
   output logic [5:0]  out_line_index,
   output logic [4:0]  out_iteration,
   output logic        out_last,
   output logic        round_done
);

   logic        out_valid_q, out_valid_d;
   logic [24:0] out_slice_q, out_slice_d;
   logic [5:0]  out_line_q, out_line_d;
   logic [4:0]  out_iter_q, out_iter_d;
   logic        out_last_q, out_last_d;
   logic        round_done_q, round_done_d;
   logic [5:0]  slice_cnt_q, slice_cnt_d;
   logic [4:0]  round_cnt_q, round_cnt_d;

   logic        accept, take, slice_end;
   logic [24:0] chi;

   // Each 5-bit row is transformed independently.
   always_comb begin
      chi = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            chi[x + 5*y] = in_slice[x + 5*y] ^
                           (~in_slice[((x + 1) % 5) + 5*y] & in_slice[((x + 2) % 5) + 5*y]);
         end
      end
   end

   assign in_ready  = ~out_valid_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign take      = out_valid_q & out_ready;
   assign slice_end = (slice_cnt_q == 6'(SLICES - 1));

   always_comb begin
      out_valid_d  = out_valid_q;
      out_slice_d  = out_slice_q;
      out_line_d   = out_line_q;
      out_iter_d   = out_iter_q;
      out_last_d   = out_last_q;
      slice_cnt_d  = slice_cnt_q;
      round_cnt_d  = round_cnt_q;
      round_done_d = take & out_last_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_slice_d = chi;
         out_line_d  = slice_cnt_q;
         out_iter_d  = round_cnt_q;
         out_last_d  = slice_end;
         slice_cnt_d = slice_end ? 6'd0 : slice_cnt_q + 6'd1;
         if (slice_end)
            round_cnt_d = (round_cnt_q == 5'(ROUNDS - 1)) ? 5'd0 : round_cnt_q + 5'd1;
      end else if (take) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_slice_q  <= '0;
         out_line_q   <= '0;
         out_iter_q   <= '0;
         out_last_q   <= 1'b0;
         round_done_q <= 1'b0;
         slice_cnt_q  <= '0;
         round_cnt_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_slice_q  <= out_slice_d;
         out_line_q   <= out_line_d;
         out_iter_q   <= out_iter_d;
         out_last_q   <= out_last_d;
         round_done_q <= round_done_d;
         slice_cnt_q  <= slice_cnt_d;
         round_cnt_q  <= round_cnt_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_slice      = out_slice_q;
   assign out_line_index = out_line_q;
   assign out_iteration  = out_iter_q;
   assign out_last       = out_last_q;
   assign round_done     = round_done_q;

endmodule

// File: tb/tb_chi_stage.sv
// Bench for chi_stage: constant vectors, directed stream/stall/wrap/reset sequences,
// and a randomized run, all checked against a transaction-count reference model.
module tb_chi_stage;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [24:0] in_slice, out_slice;
   logic [5:0]  out_line_index;
   logic [4:0]  out_iteration;
   logic        out_last, round_done;

   chi_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_slice(in_slice),
      .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
      .out_line_index(out_line_index), .out_iteration(out_iteration),
      .out_last(out_last), .round_done(round_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: n_acc counts accepts since reset; tags follow from it.
   logic        m_valid, m_last, m_done;
   logic [24:0] m_slice;
   int          m_line, m_iter, n_acc;

   typedef struct {
      logic [24:0] din;
      logic [24:0] dexp;
   } vec_t;

   function automatic logic [24:0] chi_ref(input logic [24:0] s);
      logic [24:0] r;
      logic [4:0]  row, n1, n2;
      r = '0;
      for (int y = 0; y < 5; y++) begin
         row = s[5*y +: 5];
         n1  = {row[0], row[4:1]};    // neighbour x+1
         n2  = {row[1:0], row[4:2]};  // neighbour x+2
         r[5*y +: 5] = row ^ (~n1 & n2);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock: drive, check in_ready, advance model at the edge, check outputs.
   task automatic cyc(input logic v, input logic [24:0] s, input logic ordy, input logic r);
      logic exp_rdy, acc, tk;
      in_valid = v; in_slice = s; out_ready = ordy; rst = r;
      #1;
      exp_rdy = !m_valid || ordy;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_slice = '0; m_line = 0; m_iter = 0; m_last = 0; m_done = 0; n_acc = 0;
      end else begin
         acc = v && exp_rdy;
         tk  = m_valid && ordy;
         m_done = tk && m_last;
         if (acc) begin
            m_slice = chi_ref(s);
            m_line  = n_acc % 64;
            m_iter  = (n_acc / 64) % 24;
            m_last  = (m_line == 63);
            m_valid = 1;
            n_acc++;
         end else if (tk) begin
            m_valid = 0;
         end
      end
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_slice", {7'd0, out_slice}, {7'd0, m_slice});
      chk("out_line_index", {26'd0, out_line_index}, m_line);
      chk("out_iteration", {27'd0, out_iteration}, m_iter);
      chk("out_last", {31'd0, out_last}, {31'd0, m_last});
      chk("round_done", {31'd0, round_done}, {31'd0, m_done});
   endtask

   task automatic do_reset();
      cyc(1'b0, 25'd0, 1'b1, 1'b1);
      cyc(1'b0, 25'd0, 1'b1, 1'b1);
   endtask

   initial begin
      vec_t vecs[4];
      int   nlast, ndone;
      vecs[0] = '{25'h0000001, 25'h0000009};
      vecs[1] = '{25'h0000004, 25'h0000005};
      vecs[2] = '{25'h0000000, 25'h0000000};
      vecs[3] = '{25'h1FFFFFF, 25'h1FFFFFF};

      in_valid = 0; in_slice = '0; out_ready = 1; rst = 1;
      m_valid = 0; m_slice = '0; m_line = 0; m_iter = 0; m_last = 0; m_done = 0; n_acc = 0;
      @(posedge clk); #1;
      do_reset();
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_slice", {7'd0, out_slice}, 32'd0);

      // Constant vectors, first one also checks the tags of the first accept.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, vecs[i].din, 1'b1, 1'b0);
         chk("vec_slice", {7'd0, out_slice}, {7'd0, vecs[i].dexp});
         chk("vec_line", {26'd0, out_line_index}, i);
         chk("vec_iter", {27'd0, out_iteration}, 32'd0);
      end

      // Full round back to back.
      do_reset();
      nlast = 0; ndone = 0;
      for (int i = 0; i < 65; i++) begin
         cyc(1'b1, 25'($urandom), 1'b1, 1'b0);
         if (out_valid && out_last) nlast++;
         if (round_done) ndone++;
         if (i == 64) begin
            chk("next_round_iter", {27'd0, out_iteration}, 32'd1);
            chk("next_round_line", {26'd0, out_line_index}, 32'd0);
         end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 25'd0, 1'b1, 1'b0);
         if (round_done) ndone++;
      end
      chk("last_count", nlast, 32'd1);
      chk("round_done_count", ndone, 32'd1);

      // Back-pressure hold then drain.
      do_reset();
      cyc(1'b1, 25'h0ABCDEF, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 25'($urandom), 1'b0, 1'b0);
      chk("stall_hold", {7'd0, out_slice}, {7'd0, chi_ref(25'h0ABCDEF)});
      cyc(1'b1, 25'h1234567, 1'b1, 1'b0);
      chk("drain_line", {26'd0, out_line_index}, 32'd1);
      cyc(1'b0, 25'd0, 1'b1, 1'b0);
      chk("drain_empty", {31'd0, out_valid}, 32'd0);

      // Round counter wrap after 24 rounds.
      do_reset();
      for (int i = 0; i < 24*64 + 1; i++) cyc(1'b1, 25'($urandom), 1'b1, 1'b0);
      chk("wrap_iter", {27'd0, out_iteration}, 32'd0);
      chk("wrap_line", {26'd0, out_line_index}, 32'd0);

      // Reset at round 5 slice 30.
      do_reset();
      for (int i = 0; i < 5*64 + 31; i++) cyc(1'b1, 25'($urandom), 1'b1, 1'b0);
      chk("pre_rst_iter", {27'd0, out_iteration}, 32'd5);
      chk("pre_rst_line", {26'd0, out_line_index}, 32'd30);
      cyc(1'b1, 25'h1FFFFFF, 1'b0, 1'b1);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_slice", {7'd0, out_slice}, 32'd0);
      cyc(1'b1, 25'h0000001, 1'b1, 1'b0);
      chk("post_rst_line", {26'd0, out_line_index}, 32'd0);
      chk("post_rst_iter", {27'd0, out_iteration}, 32'd0);
      chk("post_rst_slice", {7'd0, out_slice}, 32'h9);

      // Randomized handshakes with occasional reset.
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom), 25'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 299) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
